// File: rtl/hilo_divider.sv
// hilo_divider: multicycle radix-2 restoring unsigned divider with HI/LO holding registers.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, rem_nxt, quo, quo_nxt, dvs;
    logic [WIDTH:0]   rem_sh;
    logic [CW-1:0]    cnt;
    logic             ge, accept, last;

    // Stored remainder is always below the divisor, so only the shifted value needs the extra bit.
    always_comb begin
        rem_sh    = {rem, quo[WIDTH-1]};
        ge        = rem_sh >= {1'b0, dvs};
        rem_nxt   = ge ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], ge};
        accept    = start && state != RUN;
        last      = state == RUN && cnt == CW'(WIDTH - 1);
        state_nxt = state;
        if (accept)
            state_nxt = |b ? RUN : DONE;
        else if (last)
            state_nxt = DONE;
        else if (state == DONE)
            state_nxt = IDLE;
        busy = state == RUN;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Later assignments override MTHI/MTLO so a divide result wins on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (state != RUN && wr_hi)
                hi <= wdata;
            if (state != RUN && wr_lo)
                lo <= wdata;
            if (accept) begin
                quo <= a;
                dvs <= b;
                rem <= '0;
                cnt <= '0;
                if (~|b) begin
                    hi <= a;
                    lo <= '1;
                end
            end
            if (state == RUN) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    hi <= rem_nxt;
                    lo <= quo_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: directed scenario tests for hilo_divider with hand-computed results.
module tb_hilo_divider;
    logic        clk, reset, start, wr_hi, wr_lo, busy, done;
    logic [31:0] a, b, wdata, hi, lo;
    int          total, bad;

    hilo_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_div(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1;
        tick();
    endtask

    task automatic test_basic;
        start_div(32'd100, 32'd7);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_e0 busy=%b done=%b exp busy=1 done=0", busy, done); end
        for (int i = 1; i < 32; i++) begin
            tick();
            total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_busy_e%0d busy=%b done=%b exp busy=1 done=0", i, busy, done); end
        end
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_e32 done=%b busy=%b exp done=1 busy=0", done, busy); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL basic_lo got=%0d exp=14", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL basic_hi got=%0d exp=2", hi); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_e33_done got=%b exp=0", done); end
        total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL basic_hold lo=%0d hi=%0d exp lo=14 hi=2", lo, hi); end
    endtask

    task automatic test_full_range;
        int n;
        start_div(32'hFFFF_FFFF, 32'd1);
        wait_done(n);
        total++; if (n !== 32) begin bad++; $display("FAIL full1_latency got=%0d exp=32", n); end
        total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0) begin bad++; $display("FAIL full1_result lo=%h hi=%h exp lo=ffffffff hi=0", lo, hi); end
        tick();
        start_div(32'd5, 32'hFFFF_FFFF);
        wait_done(n);
        total++; if (n !== 32) begin bad++; $display("FAIL full2_latency got=%0d exp=32", n); end
        total++; if (lo !== 32'h0 || hi !== 32'd5) begin bad++; $display("FAIL full2_result lo=%h hi=%h exp lo=0 hi=5", lo, hi); end
        tick();
    endtask

    task automatic test_div_zero;
        start_div(32'h1234, 32'h0);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL dz_e0 done=%b busy=%b exp done=1 busy=0", done, busy); end
        total++; if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_result hi=%h lo=%h exp hi=1234 lo=ffffffff", hi, lo); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dz_e1 done=%b busy=%b exp done=0 busy=0", done, busy); end
    endtask

    task automatic test_ignored;
        int n;
        start_div(32'd100, 32'd7);
        repeat (9) tick();
        a = 32'd9;
        b = 32'd3;
        start = 1;
        wr_hi = 1;
        wdata = 32'hDEAD;
        tick();
        start = 0;
        wr_hi = 0;
        total++; if (hi !== 32'h1234 || busy !== 1'b1) begin bad++; $display("FAIL ign_mthi hi=%h busy=%b exp hi=1234 busy=1", hi, busy); end
        wait_done(n);
        total++; if (n !== 22) begin bad++; $display("FAIL ign_latency got=%0d exp=22", n); end
        total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL ign_result lo=%0d hi=%0d exp lo=14 hi=2", lo, hi); end
        tick();
        wr_lo = 1;
        wdata = 32'hBEEF;
        tick();
        wr_lo = 0;
        total++; if (lo !== 32'hBEEF || hi !== 32'd2) begin bad++; $display("FAIL ign_mtlo lo=%h hi=%h exp lo=beef hi=2", lo, hi); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ign_idle busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_reset_mid;
        int n, seen;
        start_div(32'd1000, 32'd3);
        repeat (14) tick();
        #2 reset = 0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_flags busy=%b done=%b exp 0 0", busy, done); end
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL rmid_hilo hi=%h lo=%h exp 0 0", hi, lo); end
        @(negedge clk);
        reset = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_quiet got=%0d active cycles exp=0", seen); end
        start_div(32'd9, 32'd3);
        wait_done(n);
        total++; if (n !== 32) begin bad++; $display("FAIL rmid_latency got=%0d exp=32", n); end
        total++; if (lo !== 32'd3 || hi !== 32'd0) begin bad++; $display("FAIL rmid_result lo=%0d hi=%0d exp lo=3 hi=0", lo, hi); end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        start_div(32'd100, 32'd7);
        wait_done(n);
        total++; if (n !== 32 || lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL b2b_first n=%0d lo=%0d hi=%0d exp n=32 lo=14 hi=2", n, lo, hi); end
        start_div(32'd50, 32'd8);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_restart busy=%b done=%b exp busy=1 done=0", busy, done); end
        wait_done(n);
        total++; if (n !== 32) begin bad++; $display("FAIL b2b_latency got=%0d exp=32", n); end
        total++; if (lo !== 32'd6 || hi !== 32'd2) begin bad++; $display("FAIL b2b_result lo=%0d hi=%0d exp lo=6 hi=2", lo, hi); end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 0;
        start = 0;
        wr_hi = 0;
        wr_lo = 0;
        a = 0;
        b = 0;
        wdata = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_range();
        test_div_zero();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_divider.md
# hilo_divider

Multicycle 32-bit unsigned divider (DIVU) and HI/LO holding register. This is the responder end of the divide handshake issued by the datapath's divide controller. Operands are captured on `start`, a radix-2 restoring division runs for 32 cycles, and the remainder and quotient are then held in HI/LO for MFHI/MFLO. The datapath uses `busy` to stall dependent instructions.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Active when 0.
- `start`  in  1  request a divide. Sampled on the rising edge.
- `a`  in  WIDTH  dividend (rs), unsigned.
- `b`  in  WIDTH  divisor (rt), unsigned.
- `wr_hi`  in  1  MTHI: load `wdata` into HI.
- `wr_lo`  in  1  MTLO: load `wdata` into LO.
- `wdata`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  a division is in progress.
- `done`  out  1  one-cycle pulse: HI/LO now hold a new result.
- `hi`  out  WIDTH  HI register, remainder after a divide.
- `lo`  out  WIDTH  LO register, quotient after a divide.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: 32 iteration cycles.
  - DONE: single cycle; `done` = 1.
- IDLE or DONE, `start` = 1:
  - Latch `a` into the quotient shift register and `b` into the divisor register.
  - Clear the 33-bit partial remainder and the 6-bit counter.
  - If `b` ≠ 0, go to RUN.
  - If `b` = 0, go straight to DONE with HI = `a` and LO = 0xFFFFFFFF.
- RUN, each edge:
  - r' = {r[31:0], q[31]}.
  - q = q << 1.
  - If r' ≥ {1'b0, divisor}: r = r' − divisor and q[0] = 1. Otherwise r = r'.
  - Increment the counter.
- RUN, on the edge that completes iteration 32: HI ← r[31:0], LO ← q, go to DONE.
- DONE → IDLE on the next edge unless `start` = 1. Back-to-back divides are allowed from DONE.
- `start` while in RUN is ignored and does not restart the operation.
- `wr_hi` / `wr_lo` are honoured only in IDLE or DONE and are ignored in RUN.
- If MTHI/MTLO and the DONE result load happen on the same edge, the divide result wins.
- HI/LO change only on:
  - a divide result,
  - a divide-by-zero result,
  - MTHI/MTLO,
  - reset.
- Arithmetic:
  - Partial remainder is WIDTH+1 bits, so the compare never overflows.
  - Results satisfy `a` = LO·`b` + HI with HI < `b`, for `b` ≠ 0.

## Timing
- Reset (`reset` = 0) is asynchronous. It forces:
  - state = IDLE,
  - `busy` = 0, `done` = 0,
  - `hi` = 0, `lo` = 0,
  - counter = 0.
- Reset during RUN aborts the operation and no `done` is produced. Operation resumes on the first `start` after `reset` returns to 1.
- Let E0 be the edge that accepts `start` with `b` ≠ 0:
  - `busy` is high from E0 to E32.
  - HI/LO are updated and `done` rises at E32, a latency of 32 cycles.
  - `done` falls at E33.
- Divide by zero accepted at E0: `busy` stays 0, HI/LO are updated and `done` = 1 at E0, `done` falls at E1.
- `hi` and `lo` are registered outputs. No combinational path runs from inputs to outputs.
- The datapath must hold MFHI/MFLO while `busy` = 1; this block does not forward in-flight results.

## Test plan
- Basic divide: a = 100, b = 7, start at E0 → `busy` 1 for E0..E31. At E32: `done` = 1, lo = 14, hi = 2. At E33: `done` = 0 and hi/lo unchanged.
- Full range: a = 0xFFFFFFFF, b = 1 → lo = 0xFFFFFFFF, hi = 0. Then a = 5, b = 0xFFFFFFFF → lo = 0, hi = 5. Both complete at E32.
- Divide by zero: a = 0x1234, b = 0 → `done` at E0+1 cycle, hi = 0x1234, lo = 0xFFFFFFFF, `busy` never 1.
- Ignored requests while busy:
  - Stimulus: a = 100, b = 7 at E0; at E10 assert `start` with a = 9, b = 3, plus `wr_hi` with wdata = 0xDEAD.
  - Response: result at E32 is still lo = 14, hi = 2.
  - Then `wr_lo` with 0xBEEF in IDLE → lo = 0xBEEF, hi = 2.
- Reset mid-operation:
  - Stimulus: start a = 1000, b = 3; drive `reset` = 0 asynchronously at cycle 15.
  - Response: `busy`, `done`, `hi`, `lo` all go to 0 immediately. No `done` follows.
  - Then a new start with a = 9, b = 3 → lo = 3, hi = 0 after 32 cycles.
- Back-to-back: `start` asserted in the DONE cycle of a first divide (a = 100, b = 7) with a = 50, b = 8 → second `done` 32 cycles later with lo = 6, hi = 2.
